// File: rtl/sw_alloc_pkg.sv
// Shared flit-type encodings, router port count and allocator helpers.
// Pure definitions: no logic, no latency.
// No flow control here; consumers decide how to use the types.
`ifndef SW_ALLOC_DEFINES_SVH
`define SW_ALLOC_DEFINES_SVH
`define PORT_NUM      5
`define TYPE_HEAD     3'd0
`define TYPE_BODY     3'd1
`define TYPE_TAIL     3'd2
`define TYPE_HEADTAIL 3'd3
`define TYPE_TEST     3'd4
`define TYPE_ACK      3'd5
`define TYPE_ACK_BACK 3'd6
`endif

package sw_alloc_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_t;

  // Flit types that close a packet and therefore release the output.
  function automatic logic is_last_flit(input logic [2:0] t);
    return (t == `TYPE_TAIL) || (t == `TYPE_HEADTAIL) || (t == `TYPE_TEST) ||
           (t == `TYPE_ACK) || (t == `TYPE_ACK_BACK);
  endfunction

  // Round-robin successor over the five ports, wrapping 4 -> 0.
  function automatic logic [2:0] next_idx(input logic [2:0] i);
    return (i == 3'd4) ? 3'd0 : i + 3'd1;
  endfunction

endpackage

// File: rtl/rr_arb5.sv
// One output port's 5-way round-robin arbiter with wormhole hold.
// Latency: winner registered, owner/busy valid the cycle after the request.
// Backpressure: while holding, all other candidates wait until tail or abort.
module rr_arb5
  import sw_alloc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] cand,
  input  logic       own_vld,
  input  logic [2:0] own_type,
  input  logic       own_req,
  output logic [2:0] owner,
  output logic       busy,
  output logic [4:0] win
);

  arb_state_t state, state_nxt;
  logic [2:0] ptr, ptr_nxt, owner_nxt;
  logic [2:0] pick;
  logic       pick_vld;
  logic [3:0] sum;
  logic [2:0] idx;

  // First candidate at or after the pointer, scanning upward with wrap.
  always_comb begin
    pick     = 3'd0;
    pick_vld = 1'b0;
    sum      = 4'd0;
    idx      = 3'd0;
    for (int k = 0; k < 5; k++) begin
      sum = {1'b0, ptr} + 4'(k);
      idx = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
      if (!pick_vld && cand[idx]) begin
        pick_vld = 1'b1;
        pick     = idx;
      end
    end
  end

  // Next-state: grab on idle, release on last flit or dropped request.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    win       = 5'd0;
    case (state)
      ARB_IDLE: begin
        if (pick_vld) begin
          state_nxt = ARB_HOLD;
          owner_nxt = pick;
          win[pick] = 1'b1;
        end
      end
      ARB_HOLD: begin
        if (!own_req || (own_vld && is_last_flit(own_type))) begin
          state_nxt = ARB_IDLE;
          ptr_nxt   = next_idx(owner);
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // State, owner and priority pointer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ARB_IDLE;
      owner <= 3'd0;
      ptr   <= 3'd0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      ptr   <= ptr_nxt;
    end
  end

  assign busy = (state == ARB_HOLD);

endmodule

// File: rtl/sw_alloc.sv
// Switch allocator: five independent output arbiters, grants transposed per input.
// Latency: one cycle request-to-grant; all outputs come straight from registers.
// Backpressure: a held output ignores other requesters until tail or abort.
module sw_alloc
  import sw_alloc_pkg::*;
#(
  parameter int PORT_NUM = `PORT_NUM
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_0,
  input  logic                req_1,
  input  logic                req_2,
  input  logic                req_3,
  input  logic                req_4,
  input  logic [PORT_NUM-1:0] port_0,
  input  logic [PORT_NUM-1:0] port_1,
  input  logic [PORT_NUM-1:0] port_2,
  input  logic [PORT_NUM-1:0] port_3,
  input  logic [PORT_NUM-1:0] port_4,
  input  logic                ovalid_0,
  input  logic                ovalid_1,
  input  logic                ovalid_2,
  input  logic                ovalid_3,
  input  logic                ovalid_4,
  input  logic [2:0]          otype_0,
  input  logic [2:0]          otype_1,
  input  logic [2:0]          otype_2,
  input  logic [2:0]          otype_3,
  input  logic [2:0]          otype_4,
  output logic [4:0]          grt_0,
  output logic [4:0]          grt_1,
  output logic [4:0]          grt_2,
  output logic [4:0]          grt_3,
  output logic [4:0]          grt_4,
  output logic [4:0]          obusy,
  output logic [2:0]          osel_0,
  output logic [2:0]          osel_1,
  output logic [2:0]          osel_2,
  output logic [2:0]          osel_3,
  output logic [2:0]          osel_4
);

  logic [4:0] req_v, vld_v, owned, busy_v;
  logic [4:0] port_v    [5];
  logic [4:0] tgt       [5];
  logic [4:0] base_cand [5];
  logic [4:0] grt_m     [5];
  logic [2:0] type_v    [5];
  logic [2:0] owner_v   [5];

  assign req_v = {req_4, req_3, req_2, req_1, req_0};
  assign vld_v = {ovalid_4, ovalid_3, ovalid_2, ovalid_1, ovalid_0};
  assign port_v[0] = port_0[4:0];
  assign port_v[1] = port_1[4:0];
  assign port_v[2] = port_2[4:0];
  assign port_v[3] = port_3[4:0];
  assign port_v[4] = port_4[4:0];
  assign type_v[0] = otype_0;
  assign type_v[1] = otype_1;
  assign type_v[2] = otype_2;
  assign type_v[3] = otype_3;
  assign type_v[4] = otype_4;

  // Keep only the lowest set bit of each target; an all-zero target requests nothing.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      tgt[i] = port_v[i] & (~port_v[i] + 5'd1);
    end
  end

  // Inputs already holding an output may not compete for another one.
  always_comb begin
    owned = 5'd0;
    for (int o = 0; o < 5; o++) begin
      if (busy_v[o]) owned[owner_v[o]] = 1'b1;
    end
  end

  // Raw candidate set per output, before the cross-output exclusion.
  always_comb begin
    for (int o = 0; o < 5; o++) begin
      base_cand[o] = 5'd0;
      for (int i = 0; i < 5; i++) begin
        base_cand[o][i] = req_v[i] & tgt[i][o] & ~owned[i];
      end
    end
  end

  // Outputs resolve in index order; a lower output's winner is masked from higher ones.
  for (genvar o = 0; o < 5; o++) begin : g_out
    logic [4:0] excl_in, cand, win;
    logic [2:0] owner;
    logic       busy;

    if (o == 0) begin : g_head
      assign excl_in = 5'd0;
    end else begin : g_link
      assign excl_in = g_out[o-1].excl_in | g_out[o-1].win;
    end

    assign cand = base_cand[o] & ~excl_in;

    rr_arb5 u_arb (
      .clk      (clk),
      .reset    (reset),
      .cand     (cand),
      .own_vld  (vld_v[owner]),
      .own_type (type_v[owner]),
      .own_req  (req_v[owner]),
      .owner    (owner),
      .busy     (busy),
      .win      (win)
    );

    assign busy_v[o]  = busy;
    assign owner_v[o] = owner;

    // A winner is never an input already claimed by a lower-index output.
    a_excl: assert property (@(posedge clk) disable iff (!reset) (win & excl_in) == 5'd0);
  end

  // Transpose registered ownership into per-input grant vectors.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      grt_m[i] = 5'd0;
      for (int o = 0; o < 5; o++) begin
        grt_m[i][o] = busy_v[o] && (owner_v[o] == 3'(i));
      end
    end
  end

  assign grt_0  = grt_m[0];
  assign grt_1  = grt_m[1];
  assign grt_2  = grt_m[2];
  assign grt_3  = grt_m[3];
  assign grt_4  = grt_m[4];
  assign obusy  = busy_v;
  assign osel_0 = busy_v[0] ? owner_v[0] : 3'd0;
  assign osel_1 = busy_v[1] ? owner_v[1] : 3'd0;
  assign osel_2 = busy_v[2] ? owner_v[2] : 3'd0;
  assign osel_3 = busy_v[3] ? owner_v[3] : 3'd0;
  assign osel_4 = busy_v[4] ? owner_v[4] : 3'd0;

endmodule

// File: tb/tb_sw_alloc.sv
// Self-checking bench for sw_alloc: per-cycle scoreboard plus directed checks.
// Latency: expected outputs are queued when inputs are driven, compared one edge later.
// Backpressure: stimulus only sends flits on outputs the reference says it owns.
module tb_sw_alloc;

  logic       clk;
  logic       reset;
  logic [4:0] req_v, vld_v;
  logic [4:0] port_v [5];
  logic [2:0] type_v [5];
  logic [4:0] grt    [5];
  logic [4:0] obusy;
  logic [2:0] osel   [5];

  typedef struct packed {
    logic [4:0][4:0] grt;
    logic [4:0]      busy;
    logic [4:0][2:0] osel;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference state per output.
  int m_busy [5];
  int m_owner[5];
  int m_ptr  [5];

  // Automatic packet sources per input.
  bit         auto_en  [5];
  int         pkts_left[5];
  int         fidx     [5];
  int         prog_len [5];
  logic [2:0] prog_t   [5][3];

  sw_alloc #(.PORT_NUM(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_0    (req_v[0]),
    .req_1    (req_v[1]),
    .req_2    (req_v[2]),
    .req_3    (req_v[3]),
    .req_4    (req_v[4]),
    .port_0   (port_v[0]),
    .port_1   (port_v[1]),
    .port_2   (port_v[2]),
    .port_3   (port_v[3]),
    .port_4   (port_v[4]),
    .ovalid_0 (vld_v[0]),
    .ovalid_1 (vld_v[1]),
    .ovalid_2 (vld_v[2]),
    .ovalid_3 (vld_v[3]),
    .ovalid_4 (vld_v[4]),
    .otype_0  (type_v[0]),
    .otype_1  (type_v[1]),
    .otype_2  (type_v[2]),
    .otype_3  (type_v[3]),
    .otype_4  (type_v[4]),
    .grt_0    (grt[0]),
    .grt_1    (grt[1]),
    .grt_2    (grt[2]),
    .grt_3    (grt[3]),
    .grt_4    (grt[4]),
    .obusy    (obusy),
    .osel_0   (osel[0]),
    .osel_1   (osel[1]),
    .osel_2   (osel[2]),
    .osel_3   (osel[3]),
    .osel_4   (osel[4])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int low_idx(input logic [4:0] p);
    for (int b = 0; b < 5; b++) if (p[b]) return b;
    return -1;
  endfunction

  function automatic bit ends_pkt(input logic [2:0] t);
    return (t == `TYPE_TAIL) || (t == `TYPE_HEADTAIL) || (t == `TYPE_TEST) ||
           (t == `TYPE_ACK) || (t == `TYPE_ACK_BACK);
  endfunction

  task automatic model_clear();
    for (int o = 0; o < 5; o++) begin
      m_busy[o] = 0; m_owner[o] = 0; m_ptr[o] = 0;
    end
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 5; i++) begin
      req_v[i] = 1'b0; vld_v[i] = 1'b0; port_v[i] = 5'd0; type_v[i] = `TYPE_BODY;
      auto_en[i] = 1'b0; pkts_left[i] = 0; fidx[i] = 0; prog_len[i] = 1;
      for (int f = 0; f < 3; f++) prog_t[i][f] = `TYPE_BODY;
    end
  endtask

  task automatic set_auto(input int i, input logic [4:0] p, input int npkt, input int len,
                          input logic [2:0] t0, input logic [2:0] t1, input logic [2:0] t2);
    auto_en[i] = 1'b1; port_v[i] = p; pkts_left[i] = npkt; prog_len[i] = len; fidx[i] = 0;
    prog_t[i][0] = t0; prog_t[i][1] = t1; prog_t[i][2] = t2;
  endtask

  // Auto sources: request while packets remain, send the next flit only when owning.
  task automatic drive_auto();
    int o;
    for (int i = 0; i < 5; i++) begin
      if (auto_en[i]) begin
        vld_v[i] = 1'b0;
        type_v[i] = `TYPE_BODY;
        if (pkts_left[i] == 0) begin
          req_v[i] = 1'b0;
        end else begin
          req_v[i] = 1'b1;
          o = low_idx(port_v[i]);
          if (o >= 0 && m_busy[o] != 0 && m_owner[o] == i) begin
            vld_v[i] = 1'b1;
            type_v[i] = prog_t[i][fidx[i]];
            fidx[i]++;
            if (fidx[i] == prog_len[i]) begin
              fidx[i] = 0;
              pkts_left[i]--;
            end
          end
        end
      end
    end
  endtask

  // Reference allocator: advance one edge from the inputs now applied, queue expectations.
  task automatic model_step();
    bit   owns[5];
    bit   taken[5];
    bit   found;
    int   ow, i;
    exp_t e;
    for (int k = 0; k < 5; k++) begin owns[k] = 1'b0; taken[k] = 1'b0; end
    for (int o = 0; o < 5; o++) if (m_busy[o] != 0) owns[m_owner[o]] = 1'b1;
    for (int o = 0; o < 5; o++) begin
      if (m_busy[o] != 0) begin
        ow = m_owner[o];
        if (!req_v[ow] || (vld_v[ow] && ends_pkt(type_v[ow]))) begin
          m_busy[o] = 0;
          m_ptr[o]  = (ow + 1) % 5;
        end
      end else begin
        found = 1'b0;
        for (int k = 0; k < 5; k++) begin
          i = (m_ptr[o] + k) % 5;
          if (!found && req_v[i] && low_idx(port_v[i]) == o && !owns[i] && !taken[i]) begin
            found = 1'b1; m_owner[o] = i; m_busy[o] = 1; taken[i] = 1'b1;
          end
        end
      end
    end
    e = '0;
    for (int o = 0; o < 5; o++) begin
      e.busy[o] = (m_busy[o] != 0);
      e.osel[o] = (m_busy[o] != 0) ? 3'(m_owner[o]) : 3'd0;
      for (int k = 0; k < 5; k++) e.grt[k][o] = (m_busy[o] != 0) && (m_owner[o] == k);
    end
    sb_q.push_back(e);
  endtask

  // One clock: drive, predict, then compare the DUT against the popped expectation.
  task automatic cycle();
    exp_t e;
    drive_auto();
    model_step();
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    for (int k = 0; k < 5; k++) chk($sformatf("grt_%0d", k), grt[k], e.grt[k]);
    chk("obusy", obusy, e.busy);
    for (int o = 0; o < 5; o++) chk($sformatf("osel_%0d", o), osel[o], e.osel[o]);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    model_clear();
    sb_q.delete();
    @(posedge clk);
    #3;
    reset = 1'b1;
  endtask

  int   got[$];
  int   exp_ord2[4] = '{0, 1, 3, 0};
  int   exp_ord3[3] = '{1, 4, 1};
  logic prev;

  initial begin
    clear_inputs();
    model_clear();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) chk($sformatf("rst_grt_%0d", k), grt[k], 5'd0);
    for (int o = 0; o < 5; o++) chk($sformatf("rst_osel_%0d", o), osel[o], 3'd0);
    chk("rst_obusy", obusy, 5'd0);

    // Single request, one-cycle grant latency.
    do_reset();
    req_v[2] = 1'b1; port_v[2] = 5'b00100;
    cycle();
    chk("s1_grt2", grt[2], 5'b00100);
    chk("s1_osel2", osel[2], 3'd2);
    chk("s1_obusy", obusy, 5'b00100);
    vld_v[2] = 1'b1; type_v[2] = `TYPE_HEADTAIL;
    cycle();
    req_v[2] = 1'b0; vld_v[2] = 1'b0;
    cycle();

    // Three inputs contending for output 4 with 3-flit packets.
    do_reset();
    set_auto(0, 5'b10000, 2, 3, `TYPE_HEAD, `TYPE_BODY, `TYPE_TAIL);
    set_auto(1, 5'b10000, 1, 3, `TYPE_HEAD, `TYPE_BODY, `TYPE_TAIL);
    set_auto(3, 5'b10000, 1, 3, `TYPE_HEAD, `TYPE_BODY, `TYPE_TAIL);
    got.delete(); prev = 1'b0;
    repeat (20) begin
      cycle();
      if (obusy[4] && !prev) got.push_back(int'(osel[4]));
      prev = obusy[4];
    end
    chk("s2_ngrants", got.size(), 4);
    for (int k = 0; k < 4 && k < got.size(); k++) chk($sformatf("s2_order_%0d", k), got[k], exp_ord2[k]);

    // Single-flit packets from inputs 1 and 4 to output 0.
    do_reset();
    set_auto(1, 5'b00001, 2, 1, `TYPE_HEADTAIL, `TYPE_BODY, `TYPE_BODY);
    set_auto(4, 5'b00001, 1, 1, `TYPE_ACK, `TYPE_BODY, `TYPE_BODY);
    got.delete(); prev = 1'b0;
    repeat (10) begin
      cycle();
      if (obusy[0] && !prev) got.push_back(int'(osel[0]));
      prev = obusy[0];
    end
    chk("s3_ngrants", got.size(), 3);
    for (int k = 0; k < 3 && k < got.size(); k++) chk($sformatf("s3_order_%0d", k), got[k], exp_ord3[k]);

    // Owner aborts mid-packet; waiting input granted one cycle after release.
    do_reset();
    req_v[2] = 1'b1; port_v[2] = 5'b00010;
    req_v[3] = 1'b1; port_v[3] = 5'b00010;
    cycle();
    chk("s4_own2", grt[2], 5'b00010);
    vld_v[2] = 1'b1; type_v[2] = `TYPE_HEAD;
    cycle();
    type_v[2] = `TYPE_BODY;
    cycle();
    chk("s4_hold", grt[2], 5'b00010);
    req_v[2] = 1'b0; vld_v[2] = 1'b0;
    cycle();
    chk("s4_drop", grt[2], 5'd0);
    chk("s4_bubble", obusy, 5'd0);
    cycle();
    chk("s4_next", grt[3], 5'b00010);
    req_v[3] = 1'b0;
    cycle();

    // Parallel grants on outputs 1 and 3 in the same cycle.
    do_reset();
    req_v[0] = 1'b1; port_v[0] = 5'b00010;
    req_v[2] = 1'b1; port_v[2] = 5'b01000;
    req_v[3] = 1'b1; port_v[3] = 5'b01000;
    cycle();
    chk("s5_grt0", grt[0], 5'b00010);
    chk("s5_grt2", grt[2], 5'b01000);
    chk("s5_grt3", grt[3], 5'd0);
    chk("s5_obusy", obusy, 5'b01010);
    req_v = 5'd0;
    cycle();

    // Non-one-hot target uses lowest bit; zero target is ignored.
    do_reset();
    req_v[1] = 1'b1; port_v[1] = 5'b10110;
    req_v[2] = 1'b1; port_v[2] = 5'b00000;
    cycle();
    chk("s7_lowbit", grt[1], 5'b00010);
    chk("s7_zero", grt[2], 5'd0);
    chk("s7_obusy", obusy, 5'b00010);
    req_v = 5'd0;
    cycle();

    // Asynchronous reset mid-packet, then pointer restarts at 0.
    do_reset();
    req_v[0] = 1'b1; port_v[0] = 5'b00001;
    cycle();
    vld_v[0] = 1'b1; type_v[0] = `TYPE_HEADTAIL;
    cycle();
    req_v[0] = 1'b0; vld_v[0] = 1'b0;
    req_v[1] = 1'b1; port_v[1] = 5'b00100;
    cycle();
    vld_v[1] = 1'b1; type_v[1] = `TYPE_HEAD;
    cycle();
    chk("s6_held", grt[1], 5'b00100);
    #3;
    reset = 1'b0;
    #1;
    chk("s6_async_grt1", grt[1], 5'd0);
    chk("s6_async_obusy", obusy, 5'd0);
    chk("s6_async_osel2", osel[2], 3'd0);
    model_clear();
    clear_inputs();
    #1;
    reset = 1'b1;
    req_v[0] = 1'b1; port_v[0] = 5'b00001;
    req_v[3] = 1'b1; port_v[3] = 5'b00001;
    cycle();
    chk("s6_ptr0_grt0", grt[0], 5'b00001);
    chk("s6_ptr0_grt3", grt[3], 5'd0);
    req_v = 5'd0;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
